// File: rtl/regfile_wb_arbiter_if.sv
// Writeback port bundle between the two writeback requesters and
// regfile_wb_arbiter. The requester side and the clear trigger use the master
// modport. The arbiter uses the slave modport.
interface regfile_wb_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_reg;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_reg;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              clr_start;
    logic              clr_busy;
    logic              grant_id;
    logic              ctrl_writeEn;
    logic [ADDR_W-1:0] ctrl_writeReg;
    logic [DATA_W-1:0] data_writeReg;

    modport master (
        output req0_valid, req0_reg, req0_data,
        output req1_valid, req1_reg, req1_data,
        output clr_start,
        input  req0_ready, req1_ready, clr_busy, grant_id,
        input  ctrl_writeEn, ctrl_writeReg, data_writeReg
    );

    modport slave (
        input  req0_valid, req0_reg, req0_data,
        input  req1_valid, req1_reg, req1_data,
        input  clr_start,
        output req0_ready, req1_ready, clr_busy, grant_id,
        output ctrl_writeEn, ctrl_writeReg, data_writeReg
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin sharing of the regfile write port between the
// ALU writeback (req0) and the load/multdiv writeback (req1). The write port
// outputs are registered.
// Optional feature macro WB_ARB_CLEAR_EN: when it is defined, a CLEAR sequencer
// is compiled in. It zeroes regs 1..31, one register per cycle.
module regfile_wb_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                 clock,
    input  logic                 ctrl_reset_n,
    regfile_wb_arbiter_if.slave  bus
);

    logic              prio;       // requester favoured on contention
    logic              grant0;
    logic              grant1;
    logic              rdy0;
    logic              rdy1;
    logic              xfer;
    logic              winner;
    logic              clr_issue;  // a clear write goes out this cycle
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] sel_reg;
    logic [DATA_W-1:0] sel_data;
    logic              write_en;
    logic [ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0] write_data;
    logic              grant_q;

    // Round-robin pick. It is built from valid and prio only, never from
    // ready, so ready does not form a combinational loop.
    always_comb begin
        grant0 = bus.req0_valid && (!bus.req1_valid || !prio);
        grant1 = bus.req1_valid && (!bus.req0_valid ||  prio);
    end

`ifdef WB_ARB_CLEAR_EN
    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;
    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_cnt_nxt;

    // FSM state and clear counter register
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state   <= IDLE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // Next state and readys. clr_start takes precedence over any grant in IDLE.
    // In CLEAR, all requesters are held off.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        rdy0        = 1'b0;
        rdy1        = 1'b0;
        clr_issue   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.clr_start) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = ADDR_W'(1);
                end else begin
                    rdy0 = grant0;
                    rdy1 = grant1;
                end
            end
            CLEAR: begin
                clr_issue   = 1'b1;
                clr_cnt_nxt = clr_cnt + 1'b1;   // wraps to 0 after the top register
                if (&clr_cnt) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.clr_busy = (state == CLEAR);
`else
    typedef enum logic {IDLE = 1'b0} state_t;
    state_t state;
    state_t state_nxt;
    logic   unused_clr;

    // FSM state register (IDLE only in this build)
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) state <= IDLE;
        else               state <= state_nxt;
    end

    // Readys come from the arbitration only
    always_comb begin
        state_nxt = state;
        rdy0      = 1'b0;
        rdy1      = 1'b0;
        case (state)
            IDLE: begin
                rdy0 = grant0;
                rdy1 = grant1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign clr_issue    = 1'b0;
    assign clr_cnt      = '0;
    assign unused_clr   = bus.clr_start;
    assign bus.clr_busy = 1'b0;
`endif

    assign xfer     = rdy0 | rdy1;
    assign winner   = rdy1;
    assign sel_reg  = rdy1 ? bus.req1_reg  : bus.req0_reg;
    assign sel_data = rdy1 ? bus.req1_data : bus.req0_data;

    // Registered write port, grant_id and priority pointer. A write to reg 0 is
    // accepted but does not raise the enable.
    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            write_en   <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
            grant_q    <= 1'b0;
            prio       <= 1'b0;
        end else begin
            write_en <= 1'b0;
            if (clr_issue) begin
                write_en   <= 1'b1;
                write_reg  <= clr_cnt;
                write_data <= '0;
            end else if (xfer) begin
                write_en   <= (sel_reg != '0);
                write_reg  <= sel_reg;
                write_data <= sel_data;
                grant_q    <= winner;
                prio       <= ~winner;
            end
        end
    end

    assign bus.req0_ready    = rdy0;
    assign bus.req1_ready    = rdy1;
    assign bus.grant_id      = grant_q;
    assign bus.ctrl_writeEn  = write_en;
    assign bus.ctrl_writeReg = write_reg;
    assign bus.data_writeReg = write_data;

endmodule
